// File: rtl/syscall_pkg.sv
// syscall_pkg: syscall codes, ASCII constants and state encodings shared by the console blocks.
package syscall_pkg;
   localparam logic [31:0] SYS_EXIT       = 32'd10;
   localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
   localparam logic [31:0] SYS_PRINT_HEX  = 32'd34;
   localparam logic [7:0]  ASCII_0        = 8'h30;
   localparam logic [7:0]  ASCII_A_LC     = 8'h61;
   localparam logic [7:0]  ASCII_NL       = 8'h0A;
   localparam logic [7:0]  ASCII_QM       = 8'h3F;
   typedef enum logic [1:0] {IDLE, HEX, NL} fmt_state_t;
   typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? ASCII_0 + {4'd0, n} : ASCII_A_LC + {4'd0, n} - 8'd10;
   endfunction
endpackage

// File: rtl/syscall_console_uart_tx_8n1.sv
// uart_tx_8n1: 8N1 LSB-first serializer; ready also rises in the last STOP cycle so frames chain with no gap.
module uart_tx_8n1
   import syscall_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       valid,
   input  logic [7:0] data,
   output logic       ready,
   output logic       txd
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   uart_state_t r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_txd;
   logic          w_last;
   assign w_last = r_cnt == CW'(CLKS_PER_BIT - 1);
   assign ready  = (r_state == U_IDLE) | ((r_state == U_STOP) & w_last);
   assign txd    = r_txd;
   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= U_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_txd   <= 1'b1;
      end else if (valid & ready) begin
         r_state <= U_START;
         r_cnt   <= '0;
         r_shift <= data;
         r_txd   <= 1'b0;
      end else begin
         case (r_state)
            U_START: begin
               r_cnt <= w_last ? '0 : r_cnt + 1'b1;
               if (w_last) begin
                  r_state <= U_DATA;
                  r_bit   <= '0;
                  r_txd   <= r_shift[0];
               end
            end
            U_DATA: begin
               r_cnt <= w_last ? '0 : r_cnt + 1'b1;
               if (w_last) begin
                  r_bit   <= r_bit + 1'b1;
                  r_shift <= r_shift >> 1;
                  r_txd   <= (r_bit == 3'd7) ? 1'b1 : r_shift[1];
                  r_state <= (r_bit == 3'd7) ? U_STOP : U_DATA;
               end
            end
            U_STOP: begin
               r_cnt <= w_last ? '0 : r_cnt + 1'b1;
               if (w_last) r_state <= U_IDLE;
            end
            default: r_txd <= 1'b1;
         endcase
      end
   end
endmodule

// File: rtl/syscall_console.sv
// syscall_console: accepts CPU syscalls, formats bytes into a FIFO and streams them out over UART.
// Build with SYSCALL_CONSOLE_ERR_EN to flag unsupported codes on err and print '?' for them.
module syscall_console
   import syscall_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        req,
   input  logic [31:0] code,
   input  logic [31:0] arg,
   output logic        ready,
   output logic        halted,
   output logic        txd,
   output logic        tx_idle
`ifdef SYSCALL_CONSOLE_ERR_EN
   ,
   output logic        err
`endif
);
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_count;
   fmt_state_t    r_state;
   logic [31:0]   r_arg;
   logic [2:0]    r_idx;
   logic          r_halted;
   logic          r_tx_busy;
   logic          w_full, w_empty, w_acc, w_bad, w_push, w_pop, w_uart_ready;
   logic [7:0]    w_din;
   assign w_full  = r_count == (AW+1)'(FIFO_DEPTH);
   assign w_empty = r_count == '0;
   assign ready   = (r_state == IDLE) & ~r_halted & ~w_full;
   assign halted  = r_halted;
   assign w_acc   = req & ready;
   assign w_pop   = ~w_empty & w_uart_ready;
   assign tx_idle = w_empty & ~r_tx_busy;
`ifdef SYSCALL_CONSOLE_ERR_EN
   logic r_err;
   assign err   = r_err;
   assign w_bad = (code != SYS_EXIT) & (code != SYS_PRINT_CHAR) & (code != SYS_PRINT_HEX);
`else
   assign w_bad = 1'b0;
`endif
   assign w_push = (w_acc & ((code == SYS_PRINT_CHAR) | w_bad)) | ((r_state != IDLE) & ~w_full);
   assign w_din  = (r_state == HEX) ? hex_ascii(r_arg[{r_idx, 2'b00} +: 4]) :
                   (r_state == NL) ? ASCII_NL :
                   (code == SYS_PRINT_CHAR) ? arg[7:0] : ASCII_QM;
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= w_din;
   end
   always_ff @(posedge clk) begin
      if (clr) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop) r_rp <= r_rp + 1'b1;
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end
   // Mirrors the transmitter leaving IDLE: set on every pop, cleared once it can take a byte and none is offered.
   always_ff @(posedge clk) begin
      if (clr) r_tx_busy <= 1'b0;
      else if (w_pop) r_tx_busy <= 1'b1;
      else if (w_uart_ready) r_tx_busy <= 1'b0;
   end
   always_ff @(posedge clk) begin
      if (clr) begin
         r_state  <= IDLE;
         r_arg    <= '0;
         r_idx    <= '0;
         r_halted <= 1'b0;
`ifdef SYSCALL_CONSOLE_ERR_EN
         r_err    <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: if (w_acc) begin
               if (code == SYS_PRINT_HEX) begin
                  r_arg   <= arg;
                  r_idx   <= 3'd7;
                  r_state <= HEX;
               end
               if (code == SYS_EXIT) r_halted <= 1'b1;
`ifdef SYSCALL_CONSOLE_ERR_EN
               if (w_bad) r_err <= 1'b1;
`endif
            end
            HEX: if (~w_full) begin
               r_idx <= r_idx - 1'b1;
               if (r_idx == 3'd0) r_state <= NL;
            end
            NL: if (~w_full) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
   uart_tx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clk  (clk),
      .clr  (clr),
      .valid(~w_empty),
      .data (r_mem[r_rp]),
      .ready(w_uart_ready),
      .txd  (txd)
   );
endmodule

// File: tb/tb_syscall_console.sv
// tb_syscall_console: directed syscalls with a UART-decoding monitor checking bytes against an expected queue.
module tb_syscall_console;
   localparam int CPB = 4;
   logic clk = 1'b0, clr = 1'b1, req = 1'b0;
   logic [31:0] code = '0, arg = '0;
   logic ready, halted, txd, tx_idle;
`ifdef SYSCALL_CONSOLE_ERR_EN
   logic err;
`endif
   int n_chk = 0, n_pass = 0, cyc = 0;
   logic [7:0] sb[$];
   logic m_act = 1'b0, b2b = 1'b0, have_last = 1'b0;
   int m_cnt = 0, last_start = 0;
   logic [7:0] m_byte = '0;

   syscall_console #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
      .clk(clk), .clr(clr), .req(req), .code(code), .arg(arg),
      .ready(ready), .halted(halted), .txd(txd), .tx_idle(tx_idle)
`ifdef SYSCALL_CONSOLE_ERR_EN
      , .err(err)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Monitor: decodes frames from txd at negedges; a clr abandons any frame in progress.
   always @(negedge clk) begin
      if (clr) begin
         m_act = 1'b0;
      end else if (!m_act) begin
         if (txd === 1'b0) begin
            m_act = 1'b1;
            m_cnt = 0;
            if (b2b && have_last) chk("frame_gap", cyc - last_start, 10*CPB);
            last_start = cyc;
            have_last = 1'b1;
         end
      end else begin
         m_cnt++;
         if (m_cnt % CPB == 0) begin
            if (m_cnt < 9*CPB) m_byte[m_cnt/CPB-1] = txd;
            else begin
               m_act = 1'b0;
               chk("stop_bit", txd, 1);
               if (sb.size() == 0) begin
                  n_chk++;
                  $display("FAIL unexpected_byte: got %0h expected none", m_byte);
               end else chk("tx_byte", m_byte, sb.pop_front());
            end
         end
      end
   end

   task automatic step;
      @(posedge clk); #1;
   endtask

   task automatic req_do(input logic [31:0] c, input logic [31:0] a);
      int n = 0;
      req = 1'b1; code = c; arg = a;
      @(negedge clk);
      while (!ready && n < 5000) begin @(negedge clk); n++; end
      if (!ready) chk("accept_timeout", 0, 1);
      step();
      req = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      @(negedge clk);
      while (!tx_idle && n < 5000) begin n++; @(negedge clk); end
      if (!tx_idle) chk("idle_timeout", 0, 1);
      step();
   endtask

   initial begin
      int n, k;
      logic saw;
      logic [7:0] hx [9] = '{8'h64, 8'h65, 8'h61, 8'h64, 8'h62, 8'h65, 8'h65, 8'h66, 8'h0A};
      repeat (2) step();
      clr = 1'b0;
      @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_txd", txd, 1);
      chk("rst_halted", halted, 0);
      chk("rst_tx_idle", tx_idle, 1);
      step();
      // print char 'A'
      sb.push_back(8'h41);
      req_do(32'd11, 32'h41);
      chk("char_busy", tx_idle, 0);
      wait_idle(n);
      chk("char_busy_cycles", n, 1 + 10*CPB);
      // print hex DEADBEEF, frames must chain without gaps
      foreach (hx[i]) sb.push_back(hx[i]);
      have_last = 1'b0; b2b = 1'b1;
      req_do(32'd34, 32'hDEADBEEF);
      k = 0;
      repeat (9) begin @(negedge clk); if (!ready) k++; end
      chk("hex_ready_low", k, 9);
      step();
      wait_idle(n);
      b2b = 1'b0;
      chk("hex_drained", sb.size(), 0);
      // held request against a 4-deep FIFO
      saw = 1'b0;
      req = 1'b1; code = 32'd11;
      for (int i = 0; i < 6; i++) begin
         arg = 32'h30 + i;
         sb.push_back(8'h30 + 8'(i));
         n = 0;
         @(negedge clk);
         while (!ready && n < 5000) begin saw = 1'b1; n++; @(negedge clk); end
         step();
      end
      req = 1'b0;
      chk("fifo_full_stall", saw, 1);
      wait_idle(n);
      chk("burst_drained", sb.size(), 0);
      // exit after a queued char
      sb.push_back(8'h41);
      req_do(32'd11, 32'h41);
      req_do(32'd10, 32'h0);
      @(negedge clk);
      chk("exit_halted", halted, 1);
      chk("exit_ready", ready, 0);
      step();
      req = 1'b1; code = 32'd11; arg = 32'h42;
      k = 0;
      repeat (10) begin @(negedge clk); if (ready) k++; end
      req = 1'b0;
      chk("halt_ignores_req", k, 0);
      step();
      wait_idle(n);
      chk("halt_drained", sb.size(), 0);
      chk("halt_sticky", halted, 1);
      // clr mid-frame with bytes queued
      clr = 1'b1; step(); clr = 1'b0;
      req_do(32'd11, 32'h55);
      req_do(32'd11, 32'h66);
      req_do(32'd11, 32'h77);
      repeat (6) @(negedge clk);
      sb.delete();
      step();
      clr = 1'b1; step(); clr = 1'b0;
      @(negedge clk);
      chk("clr_txd", txd, 1);
      chk("clr_tx_idle", tx_idle, 1);
      chk("clr_halted", halted, 0);
      chk("clr_ready", ready, 1);
      k = 0;
      repeat (50) begin @(negedge clk); if (!txd) k++; end
      chk("clr_no_frames", k, 0);
      step();
`ifdef SYSCALL_CONSOLE_ERR_EN
      chk("err_rst", err, 0);
      sb.push_back(8'h3F);
      req_do(32'd99, 32'h0);
      chk("err_set", err, 1);
      wait_idle(n);
      chk("err_drained", sb.size(), 0);
      chk("err_sticky", err, 1);
      clr = 1'b1; step(); clr = 1'b0;
      @(negedge clk);
      chk("err_clr", err, 0);
      step();
`else
      req_do(32'd99, 32'h0);
      @(negedge clk);
      chk("bad_dropped_idle", tx_idle, 1);
      chk("bad_ready", ready, 1);
      repeat (4*CPB) @(negedge clk);
      chk("bad_no_tx", txd, 1);
`endif
      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/syscall_console.md
Name: syscall_console

Overview:
Responder for the CPU's syscall requests. It accepts one request (code from $v0, argument from $a0) per handshake, formats printable bytes into a byte FIFO, and serializes them on a UART 8N1 transmit line. It also holds a sticky halt flag for the exit call. It sits beside the CPU core; its `ready` output gates the PC increment so the core stalls while the console cannot accept.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; must be >= 2.
- FIFO_DEPTH, 16, byte FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- clr  in  1  reset; synchronous, active-high.
- req  in  1  syscall request valid (syscall instruction decoded).
- code  in  32  syscall code ($v0).
- arg  in  32  syscall argument ($a0).
- ready  out  1  request accepted this cycle if req=1.
- halted  out  1  sticky exit flag.
- txd  out  1  UART serial output; idle high.
- tx_idle  out  1  FIFO empty and no frame in progress.

Behaviour:
- Reset (clr=1 at posedge):
  - FIFO emptied; formatter state goes to IDLE; UART goes to idle.
  - txd=1, halted=0, tx_idle=1.
  - ready = (state==IDLE) & ~halted & ~fifo_full, combinational from registered state. It therefore reads 1 after reset.
  - clr mid-frame aborts the frame: txd=1 after that edge, and any partially formatted output is discarded.
- Handshake: the request is accepted at the edge where req & ready. code and arg are sampled only at that edge. When req=1 and ready=0, nothing happens and the CPU must hold the request.
- Code 11 (print char): arg[7:0] is written to the FIFO at the acceptance edge. The FIFO is non-empty after that edge.
- Code 34 (print hex):
  - At acceptance, arg is latched, the digit index is set to 7, and state goes to HEX.
  - In HEX, one byte is pushed per cycle while the FIFO is not full. If full, the current digit is held and the index is not advanced.
  - Nibbles go MSB first. Values 0-9 map to 0x30+n; values a-f map to 0x61+(n-10).
  - After digit 0 comes state NL, which pushes 0x0A, then state returns to IDLE.
  - With no FIFO back-pressure this is 9 pushes in 9 consecutive cycles; ready=0 throughout.
- Code 10 (exit): halted=1 from the acceptance edge until clr. While halted, ready=0. Already-queued bytes still transmit.
- Any other code: accepted and dropped (see Optional Feature).
- FIFO:
  - Push is allowed only when the registered count < FIFO_DEPTH.
  - A pop and a push in the same cycle are both performed.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Order is strictly preserved; no byte is ever lost or duplicated.
- UART transmitter (8N1, LSB first):
  - States: IDLE, START, DATA, STOP.
  - IDLE -> START when the FIFO is non-empty at a posedge. On that edge the head is popped into the shift register and txd is driven 0.
  - Each bit is held for exactly CLKS_PER_BIT cycles. DATA sends bits 0..7 in order; STOP drives 1 for CLKS_PER_BIT cycles.
  - At the end of STOP, if the FIFO is non-empty, the next START begins on that same edge with no idle gap. Otherwise the transmitter returns to IDLE.
  - A frame is 10*CLKS_PER_BIT cycles.
- Latency for a char request: accepted at edge E0, txd falls at E1.
- tx_idle = fifo_empty & (uart_state==IDLE).

Optional Feature:
- Macro: SYSCALL_CONSOLE_ERR_EN.
- Defined:
  - Adds output port `err` (1 bit, reset 0, sticky until clr).
  - An unsupported code sets err at its acceptance edge and pushes 0x3F ('?') into the FIFO. The request is accepted only if the FIFO is not full, per the ready rule.
- Undefined: no `err` port; unsupported codes are silently dropped.

Decomposition:
- Package syscall_pkg holds:
  - SYS_EXIT=32'd10, SYS_PRINT_CHAR=32'd11, SYS_PRINT_HEX=32'd34.
  - ASCII_0=8'h30, ASCII_A_LC=8'h61, ASCII_NL=8'h0A, ASCII_QM=8'h3F.
  - Enum fmt_state_t {IDLE, HEX, NL}.
  - Enum uart_state_t {U_IDLE, U_START, U_DATA, U_STOP}.
- Sub-module uart_tx_8n1: ports clk, clr, valid, data[7:0], ready, txd; parameter CLKS_PER_BIT. The FIFO and formatter stay in the top module.

Test Plan:
1. CLKS_PER_BIT=4, clr, then req code=11 arg=0x41.
   - ready=1, accepted.
   - txd, 4 cycles per bit: 0 | 1,0,0,0,0,0,1,0 | 1.
   - tx_idle=1 after 40 cycles.
2. req code=34 arg=0xDEADBEEF.
   - ready=0 for the 9 cycles after acceptance.
   - Decoded bytes: 64 65 61 64 62 65 65 66 0A, frames back-to-back with no gap.
3. FIFO_DEPTH=4, CLKS_PER_BIT=4, req held high with code=11 and arg incrementing 0x30..0x35.
   - ready drops once the count hits 4.
   - All six bytes arrive in order, none lost.
4. Queue "A" (code 11), then req code=10.
   - halted=1 after the edge; ready=0.
   - A subsequent req code=11 is ignored.
   - 0x41 still transmits; tx_idle eventually 1.
5. Assert clr during the DATA bits of a frame with 3 bytes queued.
   - After the edge: txd=1, tx_idle=1, halted=0.
   - No further frames are sent.
6. SYSCALL_CONSOLE_ERR_EN defined, req code=99.
   - err=1 after acceptance.
   - Byte 0x3F transmitted.
   - err cleared only by clr.
